if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; sits directly upstream of the decode controller.
- Holds the PC and drives the instruction-memory address. Captures the fetched word and PC+4 into the IF/ID register, which the decoder reads.
- Handles load-use stalls, jump redirect from ID (jOnlyPCsrc/jNextPC), taken-branch redirect from MEM, and squashing of wrong-path fetches.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, word injected into IF/ID on squash.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  instruction memory address; combinational, equals pc.
- imem_rdata  in  32  instruction word; combinational read of imem_addr, same cycle.
- stall  in  1  hazard unit load-use stall; hold PC and IF/ID.
- jump_en  in  1  jump decoded in ID (controller jOnlyPCsrc).
- jump_target  in  32  jump destination (controller jNextPC).
- branch_taken  in  1  BEQ/BNE resolved taken in MEM.
- branch_target  in  32  branch destination from MEM.
- pc  out  32  current fetch PC.
- if_id_inst  out  32  instruction presented to decode.
- if_id_pc4  out  32  PC+4 of if_id_inst.
- if_id_valid  out  1  1 = if_id_inst is a real instruction; 0 = bubble.
- stall_cnt  out  CNT_W  cycles in which stall was honoured.
- flush_cnt  out  CNT_W  squash events (jump or branch).

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall or mid-redirect):
  - pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, stall_cnt=0, flush_cnt=0.
  - Release is synchronous to clk; first fetch on the first edge after release.
- Targets: jump_target and branch_target are used with bits [1:0] forced to 00.
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Per-cycle priority, highest first:
  - BRANCH (branch_taken=1): pc<=branch_target; if_id_inst<=NOP_INST; if_id_valid<=0; if_id_pc4<=0; flush_cnt++. Overrides stall and jump_en.
  - STALL (stall=1, branch_taken=0): pc, if_id_inst, if_id_pc4 and if_id_valid hold; stall_cnt++. jump_en is ignored because the held jump re-asserts next cycle.
  - JUMP (jump_en=1, stall=0, branch_taken=0): pc<=jump_target; IF/ID loaded with NOP_INST and valid=0 to squash the wrong-path fetch; flush_cnt++.
  - NORMAL: pc<=pc+4; if_id_inst<=imem_rdata; if_id_pc4<=pc+4; if_id_valid<=1.
- Latency:
  - Instruction at PC appears on if_id_inst one edge after pc=PC.
  - A jump costs exactly 1 bubble; a taken branch costs exactly 1 IF/ID bubble. Older-stage flushing is done by the downstream stages, not this block.
- Counters saturate at all-ones and never wrap.
- Outputs change only on clk edges or reset. imem_addr is the sole combinational output.
- X-safety: with stall, jump_en and branch_taken all 0 and imem_rdata known, no register takes X.

Test Plan:
- Reset then free run, imem[i]=32'h1000_0000+i: pc=0,4,8,...; if_id_inst=32'h1000_0000 with if_id_pc4=4 on edge 1, 32'h1000_0001 with if_id_pc4=8 on edge 2; if_id_valid=1 from edge 1.
- stall=1 for 3 cycles while pc=8: pc stays 8 and if_id_inst stays word@4 for 3 cycles; stall_cnt=3; pc=12 after stall drops.
- jump_en=1, jump_target=32'h0000_0043 at pc=16: next pc=32'h40; if_id_valid=0 and if_id_inst=0 for one cycle; then word@0x40 with if_id_pc4=0x44; flush_cnt=1.
- branch_taken=1, branch_target=0x80 together with stall=1 and jump_en=1: pc=0x80, bubble inserted, stall_cnt unchanged, flush_cnt+1.
- pc forced to 0xFFFF_FFFC via branch, then free run: next pc=0, if_id_pc4=0.
- rst_n pulsed low mid-cycle during a stall: all outputs to reset values immediately, without a clk edge. Separately, 70000 stall cycles: stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/if_id_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls, and IF/ID outputs.
// master = the fetch stage, slave = its surroundings (imem, controller, hazard unit, decode).
interface if_id_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             jump_en;
  logic [31:0]      jump_target;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic [31:0]      pc;
  logic [31:0]      if_id_inst;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, stall_cnt, flush_cnt,
    input  imem_rdata, stall, jump_en, jump_target, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, stall_cnt, flush_cnt,
    output imem_rdata, stall, jump_en, jump_target, branch_taken, branch_target
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC sequencing, stall hold, jump/branch
// redirect with a one-cycle squash bubble, and saturating debug event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input logic    clk,
  input logic    rst_n,
  if_id_if.master bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  jump_tgt;
  logic [XLEN-1:0]  branch_tgt;
  logic [CNT_W-1:0] stall_cnt_inc;
  logic [CNT_W-1:0] flush_cnt_inc;

  // Word-aligned targets; pc+4 wraps modulo 2^32.
  assign pc_plus4   = pc_q + XLEN'(4);
  assign jump_tgt   = {bus.jump_target[XLEN-1:2], 2'b00};
  assign branch_tgt = {bus.branch_target[XLEN-1:2], 2'b00};

  // Saturating increments: hold at all-ones.
  assign stall_cnt_inc = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
  assign flush_cnt_inc = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);

  // Priority: taken branch > stall > jump > sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.branch_taken) begin
      pc_d        = branch_tgt;
      inst_d      = NOP_INST;
      pc4_d       = '0;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt_inc;
    end else if (bus.stall) begin
      // A jump held in ID re-asserts once the stall clears, so it is not acted on here.
      stall_cnt_d = stall_cnt_inc;
    end else if (bus.jump_en) begin
      pc_d        = jump_tgt;
      inst_d      = NOP_INST;
      pc4_d       = '0;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt_inc;
    end else begin
      pc_d    = pc_plus4;
      inst_d  = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized
// redirect/stall traffic checked against an event-level reference model.
module tb_if_id_stage;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = 65535;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  if_id_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign bus.imem_rdata = imem(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  int unsigned m_scnt, m_fcnt;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic step(input logic s, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt);
    bus.stall = s; bus.jump_en = j; bus.jump_target = jt;
    bus.branch_taken = b; bus.branch_target = bt;
    if (b) begin
      m_pc = bt & 32'hFFFF_FFFC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (s) begin
      if (m_scnt < CNT_MAX) m_scnt++;
    end else if (j) begin
      m_pc = jt & 32'hFFFF_FFFC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else begin
      m_inst = imem(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.jump_target = '0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.if_id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=%h", bus.if_id_inst, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0", bus.stall_cnt, bus.flush_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    idle();
    checks++; if (bus.pc !== 32'h4 || bus.if_id_inst !== 32'h1000_0000 || bus.if_id_pc4 !== 32'h4 || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL free_run_e1 got pc=%h inst=%h pc4=%h v=%b exp pc=4 inst=10000000 pc4=4 v=1",
                         bus.pc, bus.if_id_inst, bus.if_id_pc4, bus.if_id_valid); end
    idle();
    checks++; if (bus.pc !== 32'h8 || bus.if_id_inst !== 32'h1000_0001 || bus.if_id_pc4 !== 32'h8 || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL free_run_e2 got pc=%h inst=%h pc4=%h v=%b exp pc=8 inst=10000001 pc4=8 v=1",
                         bus.pc, bus.if_id_inst, bus.if_id_pc4, bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL free_run_imem_addr got=%h exp=8", bus.imem_addr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++; if (bus.pc !== 32'h8 || bus.if_id_inst !== 32'h1000_0001 || bus.if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got pc=%h inst=%h v=%b exp pc=8 inst=10000001 v=1",
                           i, bus.pc, bus.if_id_inst, bus.if_id_valid); end
    end
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", bus.stall_cnt); end
    idle();
    checks++; if (bus.pc !== 32'hC || bus.if_id_inst !== 32'h1000_0002) begin
      errors++; $display("FAIL stall_release got pc=%h inst=%h exp pc=c inst=10000002", bus.pc, bus.if_id_inst); end
  endtask

  task automatic test_jump();
    idle();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL jump_setup_pc got=%h exp=10", bus.pc); end
    step(1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0);
    checks++; if (bus.pc !== 32'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 32'h0) begin
      errors++; $display("FAIL jump_bubble got pc=%h v=%b inst=%h exp pc=40 v=0 inst=0", bus.pc, bus.if_id_valid, bus.if_id_inst); end
    checks++; if (bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL jump_flush_cnt got=%0d exp=1", bus.flush_cnt); end
    idle();
    checks++; if (bus.if_id_inst !== 32'h1000_0010 || bus.if_id_pc4 !== 32'h44 || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL jump_target_fetch got inst=%h pc4=%h v=%b exp inst=10000010 pc4=44 v=1",
                         bus.if_id_inst, bus.if_id_pc4, bus.if_id_valid); end
  endtask

  task automatic test_branch_priority();
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080);
    checks++; if (bus.pc !== 32'h80 || bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL branch_prio got pc=%h v=%b inst=%h pc4=%h exp pc=80 v=0 inst=0 pc4=0",
                         bus.pc, bus.if_id_valid, bus.if_id_inst, bus.if_id_pc4); end
    checks++; if (bus.stall_cnt !== 16'd3 || bus.flush_cnt !== 16'd2) begin
      errors++; $display("FAIL branch_cnts got stall=%0d flush=%0d exp stall=3 flush=2", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc got=%h exp=fffffffc", bus.pc); end
    idle();
    checks++; if (bus.pc !== 32'h0 || bus.if_id_pc4 !== 32'h0 || bus.if_id_inst !== 32'h4FFF_FFFF || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL wrap got pc=%h pc4=%h inst=%h v=%b exp pc=0 pc4=0 inst=4fffffff v=1",
                         bus.pc, bus.if_id_pc4, bus.if_id_inst, bus.if_id_valid); end
  endtask

  task automatic test_random();
    logic s, j, b;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 20);
      j = ($urandom_range(0, 99) < 12);
      b = ($urandom_range(0, 99) < 8);
      step(s, j, $urandom, b, $urandom);
      checks++;
      if (bus.pc !== m_pc || bus.imem_addr !== m_pc || bus.if_id_inst !== m_inst || bus.if_id_pc4 !== m_pc4 ||
          bus.if_id_valid !== m_valid || bus.stall_cnt !== CNT_W'(m_scnt) || bus.flush_cnt !== CNT_W'(m_fcnt)) begin
        errors++;
        $display("FAIL random[%0d] got pc=%h inst=%h pc4=%h v=%b sc=%0d fc=%0d exp pc=%h inst=%h pc4=%h v=%b sc=%0d fc=%0d",
                 i, bus.pc, bus.if_id_inst, bus.if_id_pc4, bus.if_id_valid, bus.stall_cnt, bus.flush_cnt,
                 m_pc, m_inst, m_pc4, m_valid, m_scnt, m_fcnt);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.imem_addr !== 32'h0 || bus.if_id_inst !== 32'h0 || bus.if_id_pc4 !== 32'h0 ||
        bus.if_id_valid !== 1'b0 || bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got pc=%h inst=%h pc4=%h v=%b sc=%0d fc=%0d exp all zero",
               bus.pc, bus.if_id_inst, bus.if_id_pc4, bus.if_id_valid, bus.stall_cnt, bus.flush_cnt);
    end
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.branch_taken = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    checks++; if (bus.pc !== 32'h4 || bus.if_id_inst !== 32'h1000_0000 || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL async_reset_refetch got pc=%h inst=%h v=%b exp pc=4 inst=10000000 v=1",
                         bus.pc, bus.if_id_inst, bus.if_id_valid); end
  endtask

  task automatic test_saturate();
    repeat (70000) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got=%h exp=ffff", bus.stall_cnt); end
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL stall_sat_pc got=%h exp=4", bus.pc); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_random();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
